// File: rtl/lu_pkg.sv
// Shared op-code definitions for the logic-unit pipeline.
package lu_pkg;

  localparam int LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND   = 3'd0,
    LU_NAND  = 3'd1,
    LU_OR    = 3'd2,
    LU_NOR   = 3'd3,
    LU_XOR   = 3'd4,
    LU_XNOR  = 3'd5,
    LU_NOTA  = 3'd6,
    LU_PASSB = 3'd7
  } lu_op_e;

endpackage

// File: rtl/lu_core.sv
// Combinational bitwise logic unit: y = op(a, b), no carries between bits.
module lu_core
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [LU_OP_W-1:0] op,
  output logic [WIDTH-1:0]   y
);

  // One case on op selects the bitwise function.
  always_comb begin
    y = '0;
    case (op)
      LU_AND:   y = a & b;
      LU_NAND:  y = ~(a & b);
      LU_OR:    y = a | b;
      LU_NOR:   y = ~(a | b);
      LU_XOR:   y = a ^ b;
      LU_XNOR:  y = ~(a ^ b);
      LU_NOTA:  y = ~a;
      LU_PASSB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/lu_pipe.sv
// Two-stage valid/ready logic unit. S1 holds operands, S2 holds the result.
// Op evaluation sits between S1 and S2. Optional LU_CHAIN_EN adds an
// accumulator of the last result that a chained beat uses as operand A.
module lu_pipe
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [LU_OP_W-1:0] in_op,
`ifdef LU_CHAIN_EN
  input  logic               in_chain,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_zero
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [LU_OP_W-1:0] op;
`ifdef LU_CHAIN_EN
    logic               chain;
`endif
  } s1_t;

  logic [STAGES:1]  vld_pipe;
  s1_t              s1;
  logic             s2_free;
  logic             in_fire;
  logic             mv;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] y;

  // Ready ripples combinationally back from out_ready so a full pipe still
  // accepts when the consumer drains in the same cycle.
  assign s2_free   = ~vld_pipe[2] | out_ready;
  assign in_ready  = ~vld_pipe[1] | s2_free;
  assign in_fire   = in_valid & in_ready;
  assign mv        = vld_pipe[1] & s2_free;
  assign out_valid = vld_pipe[2];

`ifdef LU_CHAIN_EN
  logic [WIDTH-1:0] acc;

  // The previous beat always enters S2 before a chained beat leaves S1,
  // so acc already holds its result at evaluation time.
  assign op_a = s1.chain ? acc : s1.a;

  // acc tracks every result entering S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  acc <= '0;
    else if (mv) acc <= y;
  end
`else
  assign op_a = s1.a;
`endif

  lu_core #(.WIDTH(WIDTH)) u_core (
    .a  (op_a),
    .b  (s1.b),
    .op (s1.op),
    .y  (y)
  );

  // Valid bits and S1 operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
    end else begin
      vld_pipe[1] <= in_fire | (vld_pipe[1] & ~s2_free);
      vld_pipe[2] <= mv | (vld_pipe[2] & ~out_ready);
      if (in_fire) begin
        s1.a  <= in_a;
        s1.b  <= in_b;
        s1.op <= in_op;
`ifdef LU_CHAIN_EN
        s1.chain <= in_chain;
`endif
      end
    end
  end

  // S2 result register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_y    <= '0;
      out_zero <= 1'b0;
    end else if (mv) begin
      out_y    <= y;
      out_zero <= (y == '0);
    end
  end

endmodule

// File: tb/tb_lu_pipe.sv
// Directed bench for lu_pipe (WIDTH=8). Chain steps run only with LU_CHAIN_EN.
module tb_lu_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
`ifdef LU_CHAIN_EN
  logic       in_chain;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_zero;

  int checks = 0;
  int errors = 0;

  lu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
`ifdef LU_CHAIN_EN
    .in_chain  (in_chain),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp1 [8];

  initial begin
    exp1 = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'h3C};
    rst_n     = 1'b0;
    out_ready = 1'b1;
`ifdef LU_CHAIN_EN
    in_chain  = 1'b0;
`endif
    drive(1'b0, 8'h00, 8'h00, 3'd0);

    // Reset state
    #3;
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_out_y",     16'(out_y),     16'h0);
    check("rst_out_zero",  16'(out_zero),  16'h0);
    check("rst_in_ready",  16'(in_ready),  16'h1);
    #9 rst_n = 1'b1;
    tick();

    // 1: every op on F0/3C, output two edges after offer
    for (int op = 0; op < 8; op++) begin
      drive(1'b1, 8'hF0, 8'h3C, 3'(op));
      tick();
      in_valid = 1'b0;
      check($sformatf("op%0d_lat1", op), 16'(out_valid), 16'h0);
      tick();
      check($sformatf("op%0d_valid", op), 16'(out_valid), 16'h1);
      check($sformatf("op%0d_y", op),     16'(out_y),     16'(exp1[op]));
    end

    // 2: 16 back-to-back XOR beats, one result per cycle
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) drive(1'b1, 8'(k), 8'h5A, 3'd4);
      else        in_valid = 1'b0;
      tick();
      check($sformatf("b2b_ready%0d", k), 16'(in_ready), 16'h1);
      if (k >= 1) begin
        check($sformatf("b2b_valid%0d", k), 16'(out_valid), 16'h1);
        check($sformatf("b2b_y%0d", k),     16'(out_y),     16'(8'(k - 1) ^ 8'h5A));
      end
    end
    tick();
    check("b2b_drained", 16'(out_valid), 16'h0);

    // 3: fill with consumer stalled, then drain
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 3'd2);   // OR -> 33
    tick();
    check("fill_ready1", 16'(in_ready), 16'h1);
    drive(1'b1, 8'h0F, 8'hF3, 3'd0);   // AND -> 03
    tick();
    check("fill_ready0", 16'(in_ready), 16'h0);
    check("fill_y_a",    16'(out_y),    16'h33);
    drive(1'b1, 8'h00, 8'h77, 3'd7);   // PASSB -> 77, offered while full
    tick();
    check("stall_valid", 16'(out_valid), 16'h1);
    check("stall_y",     16'(out_y),     16'h33);
    check("stall_ready", 16'(in_ready),  16'h0);
    out_ready = 1'b1;
    #1;
    check("comb_ready",  16'(in_ready),  16'h1);
    tick();
    in_valid = 1'b0;
    check("drain_y_b",   16'(out_y),     16'h03);
    tick();
    check("drain_y_c",   16'(out_y),     16'h77);
    check("drain_v_c",   16'(out_valid), 16'h1);
    tick();
    check("drain_empty", 16'(out_valid), 16'h0);

    // 4: zero flag
    drive(1'b1, 8'hAA, 8'hAA, 3'd4);
    tick();
    drive(1'b1, 8'hAA, 8'hAA, 3'd2);
    tick();
    in_valid = 1'b0;
    check("zero_y",    16'(out_y),    16'h00);
    check("zero_flag", 16'(out_zero), 16'h1);
    tick();
    check("nz_y",      16'(out_y),    16'hAA);
    check("nz_flag",   16'(out_zero), 16'h0);
    tick();

    // 5: async reset with two beats in flight
    drive(1'b1, 8'h12, 8'h34, 3'd2);
    tick();
    drive(1'b1, 8'h55, 8'h0F, 3'd0);
    tick();
    in_valid = 1'b0;
    check("flight_valid", 16'(out_valid), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 16'(out_valid), 16'h0);
    check("arst_y",     16'(out_y),     16'h0);
    check("arst_zero",  16'(out_zero),  16'h0);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_empty", 16'(out_valid), 16'h0);
    drive(1'b1, 8'hC3, 8'h00, 3'd6);   // NOT A -> 3C
    tick();
    in_valid = 1'b0;
    check("post_rst_lat", 16'(out_valid), 16'h0);
    tick();
    check("post_rst_valid", 16'(out_valid), 16'h1);
    check("post_rst_y",     16'(out_y),     16'h3C);
    tick();

`ifdef LU_CHAIN_EN
    // 6: chained operand from previous result
    in_chain = 1'b0;
    drive(1'b1, 8'h0F, 8'hFF, 3'd0);
    tick();
    in_chain = 1'b1;
    drive(1'b1, 8'h33, 8'hF0, 3'd2);
    tick();
    in_chain = 1'b0;
    in_valid = 1'b0;
    check("chain_y1", 16'(out_y), 16'h0F);
    tick();
    check("chain_y2", 16'(out_y), 16'hFF);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    tick();
    in_chain = 1'b1;
    drive(1'b1, 8'h99, 8'h55, 3'd4);
    tick();
    in_chain = 1'b0;
    in_valid = 1'b0;
    tick();
    check("chain_rst_y", 16'(out_y), 16'h55);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
